// File: rtl/exec_pkg.sv
// exec_pkg: shared opcodes, FSM state type and datapath width for exec_unit.
package exec_pkg;
  localparam int WIDTH = 8;
  localparam logic [3:0] FS_PASS = 4'd0;
  localparam logic [3:0] FS_INC  = 4'd1;
  localparam logic [3:0] FS_ADD  = 4'd2;
  localparam logic [3:0] FS_SUB  = 4'd3;
  localparam logic [3:0] FS_DEC  = 4'd4;
  localparam logic [3:0] FS_AND  = 4'd5;
  localparam logic [3:0] FS_OR   = 4'd6;
  localparam logic [3:0] FS_XOR  = 4'd7;
  localparam logic [3:0] FS_NOT  = 4'd8;
  localparam logic [3:0] FS_SHL  = 4'd9;
  localparam logic [3:0] FS_SHR  = 4'd10;
  localparam logic [3:0] FS_MUL  = 4'd11;
  typedef enum logic [1:0] {IDLE, MUL, WB} state_t;
endpackage

// File: rtl/mul8_seq.sv
// mul8_seq: shift-add multiplier, one multiplier bit consumed per step.
module mul8_seq import exec_pkg::*; #(
  parameter int ITERS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 step,
  output logic [2*WIDTH-1:0]   product,
  output logic                 last
);
  logic [WIDTH-1:0] mcand;
  logic [3:0]       cnt;
  logic [WIDTH:0]   part;
  // multiplier sits in the low half and is shifted out as partial sums enter the top
  assign part = {1'b0, product[2*WIDTH-1:WIDTH]} + {1'b0, product[0] ? mcand : '0};
  assign last = cnt == 4'(ITERS - 1);
  always_ff @(posedge clk) begin
    if (!reset) begin
      product <= '0;
      mcand   <= '0;
      cnt     <= '0;
    end else if (load) begin
      product <= {{WIDTH{1'b0}}, b};
      mcand   <= a;
      cnt     <= '0;
    end else if (step) begin
      product <= {part, product[WIDTH-1:1]};
      cnt     <= cnt + 4'd1;
    end
  end
endmodule

// File: rtl/exec_unit.sv
// exec_unit: multi-cycle execute/write-back stage feeding the register-file write port.
module exec_unit #(
  parameter int WIDTH     = exec_pkg::WIDTH,
  parameter int MUL_ITERS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       FS,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       DA_in,
  output logic [WIDTH-1:0] Data,
  output logic [2:0]       DA,
  output logic             RW,
  output logic             busy,
  output logic             done,
  output logic             C,
  output logic             V,
  output logic             N,
  output logic             Z
);
  import exec_pkg::*;
  state_t state, state_n;
  logic [WIDTH-1:0]   a_q, b_q, y, res;
  logic [3:0]         fs_q;
  logic [2:0]         da_q;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] product;
  logic               accept, last, cin, cf, vf, wr;
  // busy also covers the registered write-back cycle, so it doubles as the start gate
  assign accept = start && !busy;
  assign wr     = fs_q <= FS_MUL;
  mul8_seq #(.ITERS(MUL_ITERS)) u_mul (
    .clk(clk), .reset(reset), .load(accept && FS == FS_MUL), .a(A), .b(B),
    .step(state == MUL), .product(product), .last(last)
  );
  always_comb begin
    state_n = state == MUL ? (last ? WB : MUL) :
              state == WB  ? IDLE :
              accept       ? (FS == FS_MUL ? MUL : WB) : IDLE;
  end
  always_comb begin
    y   = fs_q == FS_ADD ? b_q : fs_q == FS_SUB ? ~b_q : fs_q == FS_DEC ? '1 : '0;
    cin = fs_q == FS_INC || fs_q == FS_SUB;
    sum = {1'b0, a_q} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    res = '0;
    cf  = 1'b0;
    vf  = 1'b0;
    case (fs_q)
      FS_PASS: res = a_q;
      FS_INC, FS_ADD, FS_SUB, FS_DEC: begin
        res = sum[WIDTH-1:0];
        cf  = sum[WIDTH];
        vf  = (a_q[WIDTH-1] == y[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
      end
      FS_AND: res = a_q & b_q;
      FS_OR:  res = a_q | b_q;
      FS_XOR: res = a_q ^ b_q;
      FS_NOT: res = ~a_q;
      FS_SHL: begin
        res = {b_q[WIDTH-2:0], 1'b0};
        cf  = b_q[WIDTH-1];
      end
      FS_SHR: begin
        res = {1'b0, b_q[WIDTH-1:1]};
        cf  = b_q[0];
      end
      FS_MUL: begin
        res = product[WIDTH-1:0];
        cf  = |product[2*WIDTH-1:WIDTH];
      end
      default: res = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      {a_q, b_q, fs_q, da_q} <= '0;
      {Data, DA, RW, busy, done, C, V, N, Z} <= '0;
    end else begin
      state <= state_n;
      busy  <= state != IDLE || accept;
      RW    <= state == WB && wr;
      done  <= state == WB;
      if (accept) {a_q, b_q, fs_q, da_q} <= {A, B, FS, DA_in};
      if (state == WB && wr) begin
        Data <= res;
        DA   <= da_q;
        C    <= cf;
        V    <= vf;
        N    <= res[WIDTH-1];
        Z    <= res == '0;
      end
    end
  end
endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: randomized scoreboard bench for exec_unit against an arithmetic reference model.
module tb_exec_unit;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [3:0] FS = '0;
  logic [7:0] A = '0, B = '0;
  logic [2:0] DA_in = '0;
  logic [7:0] Data;
  logic [2:0] DA;
  logic RW, busy, done, C, V, N, Z;

  exec_unit dut (
    .clk(clk), .reset(reset), .start(start), .FS(FS), .A(A), .B(B), .DA_in(DA_in),
    .Data(Data), .DA(DA), .RW(RW), .busy(busy), .done(done), .C(C), .V(V), .N(N), .Z(Z)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [2:0] da;
    logic       rw;
    logic [3:0] cvnz;
    int         issue;
    int         lat;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0;
  logic [7:0] h_data = '0;
  logic [2:0] h_da = '0;
  logic [3:0] h_cvnz = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference: plain integer arithmetic on the opcode definitions
  function automatic exp_t model(input logic [3:0] fs, input logic [7:0] a, input logic [7:0] b,
                                 input logic [2:0] da);
    int ua = a, ub = b, sa = $signed(a), sb = $signed(b), r = 0, sr = 0;
    logic c = 1'b0, v = 1'b0;
    exp_t e;
    case (fs)
      4'd0: r = ua;
      4'd1: begin r = ua + 1;  sr = sa + 1;  c = r > 255; end
      4'd2: begin r = ua + ub; sr = sa + sb; c = r > 255; end
      4'd3: begin r = ua - ub; sr = sa - sb; c = ua >= ub; end
      4'd4: begin r = ua - 1;  sr = sa - 1;  c = ua != 0; end
      4'd5: r = ua & ub;
      4'd6: r = ua | ub;
      4'd7: r = ua ^ ub;
      4'd8: r = 255 - ua;
      4'd9: begin r = ub * 2; c = ub >= 128; end
      4'd10: begin r = ub / 2; c = (ub % 2) == 1; end
      4'd11: begin r = ua * ub; c = r > 255; end
      default: r = 0;
    endcase
    if (fs >= 4'd1 && fs <= 4'd4) v = sr > 127 || sr < -128;
    if (fs <= 4'd11) begin
      h_data = r[7:0];
      h_da   = da;
      h_cvnz = {c, v, r[7], r[7:0] == 8'd0};
    end
    e.data  = h_data;
    e.da    = h_da;
    e.rw    = fs <= 4'd11;
    e.cvnz  = h_cvnz;
    e.issue = 0;
    e.lat   = fs == 4'd11 ? 9 : 1;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (RW && !done) begin
      checks++;
      errors++;
      $display("FAIL rw_without_done at cycle %0d", cyc);
    end
    if (done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done Data=%0h RW=%0b with nothing expected", Data, RW);
      end else begin
        e = q.pop_front();
        chk("rw", 32'(RW), 32'(e.rw));
        chk("data", 32'(Data), 32'(e.data));
        chk("da", 32'(DA), 32'(e.da));
        chk("cvnz", 32'({C, V, N, Z}), 32'(e.cvnz));
        chk("latency", 32'(cyc - e.issue), 32'(e.lat));
        chk("busy_at_wb", 32'(busy), 32'd1);
      end
    end
  end

  task automatic issue(input logic [3:0] fs, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] da, input int extra);
    int t = 0;
    exp_t e;
    @(negedge clk);
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout busy=%0b after %0d cycles", busy, t);
    end
    start = 1'b1;
    FS = fs;
    A = a;
    B = b;
    DA_in = da;
    e = model(fs, a, b, da);
    e.issue = cyc + 1;
    q.push_back(e);
    repeat (extra) begin
      @(negedge clk);
      FS = 4'($urandom);
      A = 8'($urandom);
      B = 8'($urandom);
      DA_in = 3'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    A = 8'($urandom);
    B = 8'($urandom);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_outs"}, 32'({Data, DA, RW, busy, done, C, V, N, Z}), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_rw", 32'(RW), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end
    issue(4'd2, 8'h7F, 8'h01, 3'd3, 0);
    issue(4'd3, 8'h05, 8'h05, 3'd1, 0);
    issue(4'd9, 8'h00, 8'h81, 3'd2, 0);
    issue(4'd11, 8'h10, 8'h20, 3'd7, 0);
    issue(4'd11, 8'h0C, 8'h0B, 3'd5, 6);
    issue(4'd13, 8'h44, 8'h55, 3'd6, 2);
    issue(4'd11, 8'hFF, 8'hFF, 3'd4, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("abort");
    q.delete();
    h_data = '0;
    h_da = '0;
    h_cvnz = '0;
    reset = 1'b1;
    repeat (12) @(negedge clk);
    issue(4'd2, 8'h02, 8'h03, 3'd0, 0);
    for (int i = 0; i < 200; i++) begin
      logic [3:0] fs;
      fs = 4'($urandom_range(0, 15));
      issue(fs, 8'($urandom), 8'($urandom), 3'($urandom),
            int'($urandom_range(0, fs == 4'd11 ? 10 : 2)));
    end
    for (int t = 0; t < 100 && q.size() != 0; t++) @(negedge clk);
    chk("drain", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/exec_unit.md
# exec_unit

Multi-cycle execute and write-back stage that sits directly downstream of the 8×8-bit register file. It:
- consumes the file's A/B read-port values and a function select;
- computes an 8-bit result plus status flags;
- drives the file's write port (Data, DA, RW) with a single-cycle write pulse.

Most operations complete in one execute cycle. MUL runs an 8-iteration shift-add sequence; busy/done handshakes with the control sequencer upstream.

## Interface
Parameters:
- WIDTH, 8, datapath width. Only 8 is supported.
- MUL_ITERS, 8, multiply iterations. Must equal WIDTH.

Ports (reset is synchronous, active-low; clock and reset names match the existing register file):
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-low reset
- start  input  1  request; sampled only in IDLE
- FS  input  4  function select
- A  input  8  operand A, from register-file port A
- B  input  8  operand B, from register-file port B
- DA_in  input  3  destination register address for this operation
- Data  output  8  write-back data to the register file
- DA  output  3  write-back address to the register file
- RW  output  1  register-file write enable; one-cycle pulse
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  one-cycle pulse, coincident with write-back
- C, V, N, Z  output  1 each  carry, overflow, negative, zero; held until the next completed operation

## Operation
FS encoding:
- 0 PASS A
- 1 INC (A+1)
- 2 ADD (A+B)
- 3 SUB (A+~B+1)
- 4 DEC (A−1)
- 5 AND
- 6 OR
- 7 XOR
- 8 NOT A
- 9 SHL B (by 1, zero fill)
- 10 SHR B (by 1, zero fill)
- 11 MUL (A×B, low byte)
- 12–15 reserved

FSM states and transitions:
- IDLE: on start=1, capture A, B, FS and DA_in. Go to MUL if FS=11, otherwise to WB (result computed combinationally from the captured operands). With start=0, stay in IDLE.
- MUL: one shift-add step per cycle on a 16-bit accumulator. After exactly MUL_ITERS cycles, go to WB.
- WB: for one cycle, assert RW=1 and done=1, drive Data=result and DA=captured DA, and update the flags. Go to IDLE.

Arithmetic and flag rules:
- All results are truncated to 8 bits.
- ADD, INC, SUB, DEC: C = bit-8 carry-out (SUB: C=1 means no borrow). V = signed two's-complement overflow.
- AND, OR, XOR, NOT, PASS: C=0, V=0.
- SHL: C=B[7]. SHR: C=B[0]. V=0.
- MUL: Data = low byte. C=1 iff the high byte ≠ 0. V=0.
- All operations: N=Data[7], Z=(Data==0).

Reserved FS: the sequence still passes through WB with done=1, but RW stays 0. Data, DA and the flags are unchanged.

Boundary conditions:
- start while busy is ignored and never queued.
- start in the WB cycle is ignored; it is accepted on the next cycle, in IDLE.
- A and B may change after capture with no effect on the result.
- Reset low mid-MUL or in WB aborts: no RW pulse, and all outputs return to reset values on that edge.
- DA_in may equal an operand's register address; the write happens only at WB.

## Timing
- Reset values: state=IDLE, Data=0, DA=0, RW=0, busy=0, done=0, C=V=N=Z=0.
- Edge numbering: start is sampled high at edge 0.
- Single-cycle ops: busy=1 after edge 0. RW/done are high between edges 1 and 2. busy=0 after edge 2.
- MUL: iterations occur on edges 1–8. RW/done are high between edges 9 and 10. busy=0 after edge 10.
- Throughput:
  - one non-MUL operation every 3 cycles if start is re-asserted in IDLE;
  - one MUL every 11 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package exec_pkg holds:
  - FS opcode localparams (FS_PASS … FS_MUL);
  - the state enum (IDLE, MUL, WB);
  - WIDTH.
- Sub-module mul8_seq: sequential shift-add multiplier.
  - Ports: clk, reset, load, a, b, step, product[15:0], last.
  - exec_unit instantiates it; the ALU ops stay inline.

## Test plan
- Reset held low for 2 cycles, then released → all outputs 0, busy=0; start=0 for 5 cycles → no RW.
- ADD A=0x7F, B=0x01, DA_in=3 → RW pulse between edges 1–2 with Data=0x80, DA=3, V=1, N=1, C=0, Z=0.
- SUB A=0x05, B=0x05 → Data=0x00, Z=1, C=1; SHL B=0x81 → Data=0x02, C=1.
- MUL A=0x10, B=0x20, DA_in=7 → busy for 10 cycles, Data=0x00, C=1, Z=1, RW at edge 9.
- MUL A=0x0C, B=0x0B with start re-pulsed during MUL and with A/B changed after capture → single write of Data=0x84, C=0.
- Reset driven low at iteration 4 of MUL → no RW/done; next ADD 0x02+0x03 → Data=0x05.
